// File: rtl/rx_frame_decoder.sv
// rx_frame_decoder: parses SYNC / BCNT / payload[BCNT] frames with ESC
// byte-stuffing from one-cycle byte strobes. Adds an inter-byte timeout,
// length checking and error pulses. Completed payloads go to a double
// buffer behind a random-access read port with an avail/ack handshake.
// Optional feature macro: RX_FRAME_CHECKSUM_EN adds a trailing modulo-256
// checksum byte (sum of BCNT and payload), a CHK state and an err_chk port.
module rx_frame_decoder #(
    parameter int unsigned MAX_BYTES = 16,
    parameter int unsigned TOUT_CYC  = 100,
    parameter logic [7:0]  SYNC_BYTE = 8'h7E,
    parameter logic [7:0]  ESC_BYTE  = 8'hFE
) (
    input  logic       ct_rxclk,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [7:0] frame_len,
    output logic       frame_valid,
    output logic       frame_avail,
    input  logic       frame_ack,
    output logic       busy,
    output logic       err_len,
    output logic       err_tout,
`ifdef RX_FRAME_CHECKSUM_EN
    output logic       err_chk,
`endif
    output logic       err_resync
);

    localparam logic [7:0]  MAX8   = 8'(MAX_BYTES);
    localparam logic [31:0] TOUT32 = 32'(TOUT_CYC);

`ifdef RX_FRAME_CHECKSUM_EN
    typedef enum logic [1:0] {HUNT, BCNT, BODY, CHK} RxStateT;
`else
    typedef enum logic [1:0] {HUNT, BCNT, BODY} RxStateT;
`endif

    RxStateT     state;
    RxStateT     nextState;
    logic        escFlag;
    logic        nextEsc;
    logic [31:0] toutCnt;
    logic [31:0] toutNext;
    logic [7:0]  rxCount;
    logic [7:0]  pendLen;
    logic [7:0]  workBuf [MAX_BYTES];
    logic [7:0]  outBuf  [MAX_BYTES];

    logic        latchLen;
    logic        writeData;
    logic        clearCount;
    logic        doComplete;
    logic        pulseLen;
    logic        pulseResync;
    logic        pulseTout;
`ifdef RX_FRAME_CHECKSUM_EN
    logic [7:0]  sumAcc;
    logic        pulseChk;
`endif

    // State register, escape flag and inter-byte timeout counter
    always_ff @(posedge ct_rxclk or negedge reset) begin
        if (!reset) begin
            state   <= HUNT;
            escFlag <= 1'b0;
            toutCnt <= '0;
        end else begin
            state   <= nextState;
            escFlag <= nextEsc;
            toutCnt <= toutNext;
        end
    end

    // Next-state decode: escape handling first, then SYNC, then per-state data
    always_comb begin
        nextState   = state;
        nextEsc     = escFlag;
        toutNext    = toutCnt;
        latchLen    = 1'b0;
        writeData   = 1'b0;
        clearCount  = 1'b0;
        doComplete  = 1'b0;
        pulseLen    = 1'b0;
        pulseResync = 1'b0;
        pulseTout   = 1'b0;
`ifdef RX_FRAME_CHECKSUM_EN
        pulseChk    = 1'b0;
`endif
        if (byte_valid) begin
            toutNext = '0;
            if (!escFlag && byte_data == ESC_BYTE) begin
                nextEsc = 1'b1;
            end else if (!escFlag && byte_data == SYNC_BYTE) begin
                nextState   = BCNT;
                clearCount  = 1'b1;
                pulseResync = (state == BCNT) || (state == BODY);
            end else begin
                nextEsc = 1'b0;
                case (state)
                    BCNT: begin
                        if (byte_data == 8'd0 || byte_data > MAX8) begin
                            pulseLen  = 1'b1;
                            nextState = HUNT;
                        end else begin
                            latchLen  = 1'b1;
                            nextState = BODY;
                        end
                    end
                    BODY: begin
                        writeData = 1'b1;
                        if (rxCount + 8'd1 == pendLen) begin
`ifdef RX_FRAME_CHECKSUM_EN
                            nextState = CHK;
`else
                            doComplete = 1'b1;
                            nextState  = HUNT;
`endif
                        end
                    end
`ifdef RX_FRAME_CHECKSUM_EN
                    CHK: begin
                        if (byte_data == sumAcc) begin
                            doComplete = 1'b1;
                        end else begin
                            pulseChk = 1'b1;
                        end
                        nextState = HUNT;
                    end
`endif
                    default: ;
                endcase
            end
        end else if (state != HUNT) begin
            if (toutCnt + 32'd1 == TOUT32) begin
                pulseTout = 1'b1;
                nextState = HUNT;
                toutNext  = '0;
            end else begin
                toutNext = toutCnt + 32'd1;
            end
        end else begin
            toutNext = '0;
        end
        if (nextState == HUNT && state != HUNT) begin
            nextEsc = 1'b0;
        end
    end

    // Working side: receive count, pending length, running sum and payload capture
    always_ff @(posedge ct_rxclk or negedge reset) begin
        if (!reset) begin
            rxCount <= '0;
            pendLen <= '0;
`ifdef RX_FRAME_CHECKSUM_EN
            sumAcc  <= '0;
`endif
            for (int i = 0; i < int'(MAX_BYTES); i++) begin
                workBuf[i] <= '0;
            end
        end else begin
            if (clearCount) begin
                rxCount <= '0;
            end else if (writeData) begin
                rxCount <= rxCount + 8'd1;
            end
            if (latchLen) begin
                pendLen <= byte_data;
            end
`ifdef RX_FRAME_CHECKSUM_EN
            if (latchLen) begin
                sumAcc <= byte_data;
            end else if (writeData) begin
                sumAcc <= sumAcc + byte_data;
            end
`endif
            if (writeData) begin
                for (int i = 0; i < int'(MAX_BYTES); i++) begin
                    if (8'(i) == rxCount) begin
                        workBuf[i] <= byte_data;
                    end
                end
            end
        end
    end

    // Output side: publish the finished payload (final byte merged in) and drive pulses
    always_ff @(posedge ct_rxclk or negedge reset) begin
        if (!reset) begin
            frame_len   <= '0;
            frame_valid <= 1'b0;
            frame_avail <= 1'b0;
            err_len     <= 1'b0;
            err_tout    <= 1'b0;
            err_resync  <= 1'b0;
`ifdef RX_FRAME_CHECKSUM_EN
            err_chk     <= 1'b0;
`endif
            for (int i = 0; i < int'(MAX_BYTES); i++) begin
                outBuf[i] <= '0;
            end
        end else begin
            frame_valid <= doComplete;
            err_len     <= pulseLen;
            err_tout    <= pulseTout;
            err_resync  <= pulseResync;
`ifdef RX_FRAME_CHECKSUM_EN
            err_chk     <= pulseChk;
`endif
            if (doComplete) begin
                frame_len <= pendLen;
                for (int i = 0; i < int'(MAX_BYTES); i++) begin
                    outBuf[i] <= (writeData && 8'(i) == rxCount) ? byte_data : workBuf[i];
                end
            end
            if (doComplete) begin
                frame_avail <= 1'b1;
            end else if (frame_ack) begin
                frame_avail <= 1'b0;
            end
        end
    end

    assign busy = (state != HUNT);

    // Random-access read of the published payload; zero beyond the frame length
    always_comb begin
        rd_data = 8'h00;
        for (int i = 0; i < int'(MAX_BYTES); i++) begin
            if (rd_addr == 8'(i) && rd_addr < frame_len) begin
                rd_data = outBuf[i];
            end
        end
    end

endmodule

// File: tb/tb_rx_frame_decoder.sv
// tb_rx_frame_decoder: randomized frames against a queue-based frame model,
// checked every cycle, plus directed sequences with literal expectations.
module tb_rx_frame_decoder;

    localparam int         MAXB = 16;
    localparam int         TOUT = 100;
    localparam logic [7:0] SYNC = 8'h7E;
    localparam logic [7:0] ESC  = 8'hFE;

    logic       ct_rxclk = 1'b0;
    logic       reset = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic [7:0] rd_addr = 8'h00;
    logic       frame_ack = 1'b0;
    logic [7:0] rd_data;
    logic [7:0] frame_len;
    logic       frame_valid;
    logic       frame_avail;
    logic       busy;
    logic       err_len;
    logic       err_tout;
    logic       err_resync;
`ifdef RX_FRAME_CHECKSUM_EN
    logic       err_chk;
`endif

    rx_frame_decoder dut (
        .ct_rxclk   (ct_rxclk),
        .reset      (reset),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .frame_len  (frame_len),
        .frame_valid(frame_valid),
        .frame_avail(frame_avail),
        .frame_ack  (frame_ack),
        .busy       (busy),
        .err_len    (err_len),
        .err_tout   (err_tout),
`ifdef RX_FRAME_CHECKSUM_EN
        .err_chk    (err_chk),
`endif
        .err_resync (err_resync)
    );

    always #5 ct_rxclk = ~ct_rxclk;

    int checks = 0;
    int failures = 0;
    bit randAck = 0;
    bit randRd = 0;
    logic [7:0] seq[$];

    // Frame model: destuffed bytes since the last SYNC, [0] is BCNT
    bit         mInFrame, mEsc, mAvail, mValid, mErrLen, mErrTout, mErrResync, mErrChk;
    logic [7:0] mQ[$];
    int         mIdle;
    logic [7:0] mOut[256];
    logic [7:0] mLen;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void modelReset();
        mInFrame = 0; mEsc = 0; mAvail = 0; mValid = 0;
        mErrLen = 0; mErrTout = 0; mErrResync = 0; mErrChk = 0;
        mQ.delete(); mIdle = 0; mLen = 0;
        for (int i = 0; i < 256; i++) mOut[i] = 8'h00;
    endfunction

    function automatic bit inChkPhase();
`ifdef RX_FRAME_CHECKSUM_EN
        return mInFrame && mQ.size() >= 1 && mQ.size() == int'(mQ[0]) + 1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic void modelStep(input bit bv, input logic [7:0] bd, input bit ack);
        bit done;
        logic [7:0] sum;
        done = 0; mValid = 0; mErrLen = 0; mErrTout = 0; mErrResync = 0; mErrChk = 0;
        if (bv) begin
            mIdle = 0;
            if (!mEsc && bd == ESC) begin
                mEsc = 1;
            end else if (!mEsc && bd == SYNC) begin
                mErrResync = mInFrame && !inChkPhase();
                mInFrame = 1;
                mQ.delete();
            end else begin
                mEsc = 0;
                if (mInFrame) begin
                    if (inChkPhase()) begin
                        sum = 8'h00;
                        foreach (mQ[i]) sum = sum + mQ[i];
                        if (sum == bd) done = 1; else mErrChk = 1;
                        mInFrame = 0;
                    end else begin
                        mQ.push_back(bd);
                        if (mQ.size() == 1) begin
                            if (bd == 8'h00 || int'(bd) > MAXB) begin
                                mErrLen = 1;
                                mInFrame = 0;
                            end
                        end else if (mQ.size() == int'(mQ[0]) + 1) begin
`ifndef RX_FRAME_CHECKSUM_EN
                            done = 1;
                            mInFrame = 0;
`endif
                        end
                    end
                end
            end
        end else if (mInFrame) begin
            mIdle++;
            if (mIdle == TOUT) begin
                mErrTout = 1;
                mInFrame = 0;
                mEsc = 0;
            end
        end
        if (!mInFrame) mIdle = 0;
        if (done) begin
            mLen = mQ[0];
            for (int i = 0; i < int'(mLen); i++) mOut[i] = mQ[i+1];
            mValid = 1;
        end
        mAvail = done ? 1'b1 : (ack ? 1'b0 : mAvail);
    endfunction

    // Every-cycle comparison of all outputs against the model
    initial begin
        modelReset();
        forever begin
            @(posedge ct_rxclk);
            if (!reset) modelReset();
            else modelStep(byte_valid, byte_data, frame_ack);
            #1;
            checkOutput("frame_valid", frame_valid, mValid);
            checkOutput("frame_avail", frame_avail, mAvail);
            checkOutput("frame_len", frame_len, mLen);
            checkOutput("busy", busy, mInFrame);
            checkOutput("err_len", err_len, mErrLen);
            checkOutput("err_tout", err_tout, mErrTout);
            checkOutput("err_resync", err_resync, mErrResync);
`ifdef RX_FRAME_CHECKSUM_EN
            checkOutput("err_chk", err_chk, mErrChk);
`endif
            checkOutput("rd_data", rd_data, (rd_addr < mLen) ? mOut[rd_addr] : 8'h00);
        end
    end

    task automatic applyStimulus(input bit v, input logic [7:0] d, input bit ack);
        byte_valid = v;
        byte_data  = v ? d : 8'($urandom);
        frame_ack  = ack | (randAck && ($urandom_range(0, 5) == 0));
        if (randRd) rd_addr = 8'($urandom_range(0, MAXB + 2));
        @(negedge ct_rxclk);
        byte_valid = 1'b0;
        frame_ack  = 1'b0;
    endtask

    task automatic sendSeq();
        foreach (seq[i]) applyStimulus(1'b1, seq[i], 1'b0);
    endtask

    task automatic checkRd(input logic [7:0] addr, input logic [7:0] exp, input string name);
        rd_addr = addr;
        #1;
        checkOutput(name, rd_data, exp);
    endtask

    function automatic logic [7:0] pickByte();
        case ($urandom_range(0, 5))
            0:       return SYNC;
            1:       return ESC;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic sendStuffed(input logic [7:0] b);
        if (b == SYNC || b == ESC) applyStimulus(1'b1, ESC, 1'b0);
        applyStimulus(1'b1, b, 1'b0);
    endtask

    task automatic sendRandomFrame();
        int kind, len, nPay, cut;
        logic [7:0] raw[$];
        logic [7:0] s;
        kind = $urandom_range(0, 11);
        len  = $urandom_range(1, MAXB);
        if (kind == 0) len = 0;
        if (kind == 1) len = $urandom_range(MAXB + 1, 255);
        nPay = (kind <= 1) ? 0 : len;
        raw = {};
        raw.push_back(8'(len));
        for (int i = 0; i < nPay; i++) raw.push_back(pickByte());
`ifdef RX_FRAME_CHECKSUM_EN
        if (kind > 1) begin
            s = 8'h00;
            foreach (raw[i]) s = s + raw[i];
            if (kind == 2) s = s + 8'h01;
            raw.push_back(s);
        end
`else
        s = 8'h00;
`endif
        cut = $urandom_range(0, raw.size() - 1);
        applyStimulus(1'b1, SYNC, 1'b0);
        foreach (raw[i]) begin
            if (kind == 3 && i == cut) applyStimulus(1'b1, SYNC, 1'b0);
            if (kind == 4 && i == cut) repeat (TOUT + $urandom_range(0, 2) - 1) applyStimulus(1'b0, s, 1'b0);
            sendStuffed(raw[i]);
            repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 8'h00, 1'b0);
        end
        if (kind == 5) repeat ($urandom_range(1, 4)) applyStimulus(1'b1, pickByte(), 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge ct_rxclk);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_frame_len", frame_len, 8'h00);
        checkOutput("reset_rd_data", rd_data, 8'h00);
        checkOutput("reset_frame_avail", frame_avail, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge ct_rxclk);

`ifndef RX_FRAME_CHECKSUM_EN
        seq = {8'h7E, 8'h03, 8'h11, 8'h22, 8'h33};
        sendSeq();
        checkOutput("basic_valid", frame_valid, 1'b1);
        checkOutput("basic_len", frame_len, 8'd3);
        checkRd(8'd0, 8'h11, "basic_rd0");
        checkRd(8'd1, 8'h22, "basic_rd1");
        checkRd(8'd2, 8'h33, "basic_rd2");
        checkRd(8'd3, 8'h00, "basic_rd3");
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("basic_valid_drop", frame_valid, 1'b0);
        checkOutput("basic_avail_hold", frame_avail, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("basic_ack", frame_avail, 1'b0);

        seq = {8'h7E, 8'h02, 8'hFE, 8'h7E, 8'hFE, 8'hFE};
        sendSeq();
        checkOutput("esc_len", frame_len, 8'd2);
        checkRd(8'd0, 8'h7E, "esc_rd0");
        checkRd(8'd1, 8'hFE, "esc_rd1");

        seq = {8'h7E, 8'h05, 8'hAA, 8'h7E};
        sendSeq();
        checkOutput("resync_pulse", err_resync, 1'b1);
        seq = {8'h01, 8'hBB};
        sendSeq();
        checkOutput("resync_valid", frame_valid, 1'b1);
        checkOutput("resync_len", frame_len, 8'd1);
        checkRd(8'd0, 8'hBB, "resync_rd0");

        seq = {8'h7E, 8'h00};
        sendSeq();
        checkOutput("len0_err", err_len, 1'b1);
        checkOutput("len0_busy", busy, 1'b0);
        seq = {8'h7E, 8'h11};
        sendSeq();
        checkOutput("len17_err", err_len, 1'b1);
        checkOutput("len17_busy", busy, 1'b0);

        seq = {8'h7E, 8'h04, 8'h01};
        sendSeq();
        repeat (TOUT - 1) applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("tout_early", err_tout, 1'b0);
        checkOutput("tout_busy_early", busy, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("tout_pulse", err_tout, 1'b1);
        checkOutput("tout_busy", busy, 1'b0);
        checkOutput("tout_len_kept", frame_len, 8'd1);
        checkRd(8'd0, 8'hBB, "tout_rd_kept");
`else
        seq = {8'h7E, 8'h02, 8'h10, 8'h20, 8'h32};
        sendSeq();
        checkOutput("chk_ok_valid", frame_valid, 1'b1);
        checkOutput("chk_ok_len", frame_len, 8'd2);
        checkRd(8'd1, 8'h20, "chk_ok_rd1");
        seq = {8'h7E, 8'h02, 8'h10, 8'h20, 8'h33};
        sendSeq();
        checkOutput("chk_bad_err", err_chk, 1'b1);
        checkOutput("chk_bad_valid", frame_valid, 1'b0);
`endif

        seq = {8'h7E, 8'h02, 8'h55};
        sendSeq();
        rd_addr = 8'd0;
        reset = 1'b0;
        #1;
        checkOutput("midreset_busy", busy, 1'b0);
        checkOutput("midreset_len", frame_len, 8'h00);
        checkOutput("midreset_rd", rd_data, 8'h00);
        checkOutput("midreset_avail", frame_avail, 1'b0);
        checkOutput("midreset_valid", frame_valid, 1'b0);
        repeat (2) @(negedge ct_rxclk);
        reset = 1'b1;
        @(negedge ct_rxclk);

        randAck = 1'b1;
        randRd  = 1'b1;
        repeat (300) begin
            sendRandomFrame();
            repeat ($urandom_range(0, 4)) applyStimulus(1'b0, 8'h00, 1'b0);
        end
        randAck = 1'b0;
        repeat (TOUT + 5) applyStimulus(1'b0, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rx_frame_decoder.md
Name:
rx_frame_decoder

Overview:
- Parametrised successor to the single-buffer UART RX message decoder.
- Takes one-cycle byte strobes from the RX unloader on ct_rxclk and parses frames of the form SYNC, BCNT, payload[BCNT], with ESC byte-stuffing.
- Stores each completed payload in a double buffer and presents it on a random-access read port for the LED/display or host logic.
- Adds what the previous decoder lacked: inter-byte timeout, length checking, error pulses and a completion handshake.

Parameters:
- MAX_BYTES, 16, payload capacity in bytes (1..255).
- TOUT_CYC, 100, ct_rxclk cycles allowed between bytes inside a frame before abort (1..2^32-1).
- SYNC_BYTE, 8'h7E, frame start delimiter.
- ESC_BYTE, 8'hFE, escape prefix; the next byte is taken literally.

Ports:
- ct_rxclk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- byte_valid  in  1  one-cycle strobe; byte_data is valid this cycle
- byte_data  in  8  received byte
- rd_addr  in  8  payload read index
- rd_data  out  8  completed-payload byte at rd_addr, combinational
- frame_len  out  8  byte count of the last completed frame
- frame_valid  out  1  one-cycle pulse when a frame completes
- frame_avail  out  1  high while an unacknowledged completed frame is held
- frame_ack  in  1  clears frame_avail
- busy  out  1  high when state is not HUNT
- err_len  out  1  pulse: BCNT is 0 or greater than MAX_BYTES
- err_tout  out  1  pulse: inter-byte timeout
- err_resync  out  1  pulse: unescaped SYNC arrived mid-frame

Behaviour:
- Reset (reset=0, async): state=HUNT, escape flag=0, timeout counter=0, rx count=0, frame_len=0, both buffers zeroed, every output pulse and flag=0, rd_data=0.
- All logic is clocked on posedge ct_rxclk. Bytes are processed in the cycle byte_valid=1. Each byte takes one cycle, so back-to-back strobes are legal.
- Escape handling:
  - Unescaped ESC_BYTE sets the escape flag, consumes no state, and does not advance the state.
  - The next byte clears the flag and is treated as data in the current state, including when it equals SYNC_BYTE or ESC_BYTE.
- Unescaped SYNC_BYTE:
  - In any state, go to BCNT and clear rx count.
  - If it arrives in BCNT or BODY, also pulse err_resync; the partial frame is discarded.
- States:
  - HUNT: non-SYNC bytes are ignored.
  - BCNT: a byte of 0 or greater than MAX_BYTES pulses err_len and returns to HUNT. Otherwise it latches the pending length and moves to BODY.
  - BODY: writes the byte to working buffer[rx count] and increments rx count. When rx count reaches the pending length, the frame completes (or moves to CHK when the optional feature is compiled in).
  - CHK: exists only with the optional feature.
- Completion, in the cycle after the last byte is processed:
  - Working buffer is copied to the output buffer; frame_len = pending length.
  - frame_valid pulses for 1 cycle, frame_avail is set, and the state returns to HUNT.
  - Latency is 1 cycle from the last byte's strobe to frame_valid.
- Overrun: a frame completing while frame_avail=1 still overwrites the output buffer. frame_avail stays 1.
- frame_ack=1 clears frame_avail next cycle. If a completion lands in the same cycle as the ack, completion wins and frame_avail=1.
- rd_data = output buffer[rd_addr] when rd_addr < frame_len, else 8'h00.
- Timeout:
  - The counter increments every cycle while busy and byte_valid=0, and clears on byte_valid=1 or in HUNT.
  - Reaching TOUT_CYC pulses err_tout, returns to HUNT and clears the escape flag. The output buffer is untouched.
- Error pulses are mutually exclusive and last 1 cycle. A pending escape flag is cleared on any return to HUNT.

Optional Feature:
- Macro: RX_FRAME_CHECKSUM_EN.
- Defined:
  - After the last payload byte, go to CHK and expect one trailing checksum byte, subject to escape rules.
  - The checksum is the 8-bit modulo-256 sum of BCNT plus all payload bytes.
  - On a match, complete as above. On a mismatch, pulse err_chk (extra 1-bit output port, present only when defined), discard the frame and return to HUNT.
- Undefined: there is no CHK state and no err_chk port; the frame completes after the last payload byte.

Test Plan:
- Bytes 7E 03 11 22 33 -> frame_valid 1 cycle after 33; frame_len=3; rd_addr 0..3 gives 11,22,33,00; frame_avail=1 until frame_ack.
- 7E 02 FE 7E FE FE -> frame_len=2; payload 7E,FE; no error pulses.
- 7E 05 AA, then 7E 01 BB -> err_resync at the second 7E; frame_len=1, payload BB.
- 7E 00 -> err_len; 7E 11 (17 > MAX_BYTES=16) -> err_len; busy=0 after each.
- 7E 04 01, then idle 100 cycles -> err_tout exactly at cycle 100, busy=0, prior output buffer unchanged; reset asserted mid-frame -> all outputs 0 immediately.
- With RX_FRAME_CHECKSUM_EN: 7E 02 10 20 32 -> frame_valid; 7E 02 10 20 33 -> err_chk, no frame_valid.
